// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard stall controller: instruction field slices,
// opcode/register constants, default bubble encoding and stall FSM states.
package hazard_stall_ctrl_pkg;

    localparam logic [7:0] BUBBLE_INST_DEFAULT = 8'h00;
    localparam logic [2:0] OP_ORI              = 3'b111;
    localparam logic [1:0] K1_IDX              = 2'b01;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL1 = 2'd1,
        STALL2 = 2'd2
    } stall_state_e;

    function automatic logic [1:0] inst_rd(input logic [7:0] inst);
        return inst[7:6];
    endfunction

    function automatic logic [1:0] inst_rs(input logic [7:0] inst);
        return inst[5:4];
    endfunction

    function automatic logic [2:0] inst_op(input logic [7:0] inst);
        return inst[2:0];
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing signal bundle of the stall controller; the master side feeds
// fetch/comparator results, the slave side is the controller itself.
interface hazard_stall_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic [7:0]             inst_in;
    logic                   inst_in_valid;
    logic                   hazard;
    logic                   flush;
    logic [7:0]             instb;
    logic [7:0]             instm;
    logic [7:0]             instf;
    logic                   valid_b;
    logic                   valid_m;
    logic                   valid_f;
    logic                   pc_we;
    logic                   ir_we;
    logic                   stalled;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output inst_in, inst_in_valid, hazard, flush,
        input  instb, instm, instf, valid_b, valid_m, valid_f,
        input  pc_we, ir_we, stalled, stall_count
    );

    modport slave (
        input  inst_in, inst_in_valid, hazard, flush,
        output instb, instm, instf, valid_b, valid_m, valid_f,
        output pc_we, ir_we, stalled, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl_pipe_stage_reg.sv
// One pipeline stage: 8-bit instruction plus valid bit.
// Priority: reset, then bubble injection, then load; otherwise the stage holds.
module pipe_stage_reg
    import hazard_stall_ctrl_pkg::*;
#(
    parameter logic [7:0] BUBBLE_INST = BUBBLE_INST_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic       bubble_i,
    input  logic [7:0] inst_d_i,
    input  logic       valid_d_i,
    output logic [7:0] inst_o,
    output logic       valid_o
);
    logic [7:0] inst_q;
    logic       valid_q;

    always_ff @(posedge clock) begin
        if (reset || bubble_i) begin
            inst_q  <= BUBBLE_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            inst_q  <= inst_d_i;
            valid_q <= valid_d_i;
        end
    end

    assign inst_o  = inst_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// B/M/F instruction chain with stall/flush control. Optional saturating stall
// counter is built only when HAZARD_STALL_STATS_EN is defined.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter logic [7:0] BUBBLE_INST = BUBBLE_INST_DEFAULT,
    parameter int         STALL_CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);
    logic [7:0]   b_inst, m_inst, f_inst;
    logic         b_vld, m_vld, f_vld;
    logic         stall_now;
    stall_state_e state_q, state_d;

    // Reset is folded in so fetch stays enabled while the chain is being cleared.
    assign stall_now = bus.hazard & b_vld & (m_vld | f_vld) & ~bus.flush & ~reset;

    pipe_stage_reg #(.BUBBLE_INST(BUBBLE_INST)) u_stage_b (
        .clock    (clock),
        .reset    (reset),
        .load_i   (~stall_now),
        .bubble_i (bus.flush),
        .inst_d_i (bus.inst_in),
        .valid_d_i(bus.inst_in_valid),
        .inst_o   (b_inst),
        .valid_o  (b_vld)
    );

    pipe_stage_reg #(.BUBBLE_INST(BUBBLE_INST)) u_stage_m (
        .clock    (clock),
        .reset    (reset),
        .load_i   (1'b1),
        .bubble_i (bus.flush | stall_now),
        .inst_d_i (b_inst),
        .valid_d_i(b_vld),
        .inst_o   (m_inst),
        .valid_o  (m_vld)
    );

    pipe_stage_reg #(.BUBBLE_INST(BUBBLE_INST)) u_stage_f (
        .clock    (clock),
        .reset    (reset),
        .load_i   (1'b1),
        .bubble_i (1'b0),
        .inst_d_i (m_inst),
        .valid_d_i(m_vld),
        .inst_o   (f_inst),
        .valid_o  (f_vld)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        if (!bus.flush) begin
            unique case (state_q)
                RUN:     state_d = stall_now ? STALL1 : RUN;
                STALL1:  state_d = stall_now ? STALL2 : RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Two stalls drain both M and F to bubbles, so a third is impossible.
    assert property (@(posedge clock) disable iff (reset)
        !(state_q == STALL2 && stall_now));

`ifdef HAZARD_STALL_STATS_EN
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    always_comb cnt_d = stall_now ? sat_inc(cnt_q) : cnt_q;

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.stall_count = cnt_q;
`else
    assign bus.stall_count = '0;
`endif

    assign bus.instb   = b_inst;
    assign bus.instm   = m_inst;
    assign bus.instf   = f_inst;
    assign bus.valid_b = b_vld;
    assign bus.valid_m = m_vld;
    assign bus.valid_f = f_vld;
    assign bus.pc_we   = ~stall_now;
    assign bus.ir_we   = ~stall_now;
    assign bus.stalled = (state_q != RUN);
endmodule
